// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl: Avalon-MM 4-digit 7-segment driver with hex/BCD decode, blanking, polarity and PWM dimming (optional irq via SEG7_DISPLAY_IRQ_EN)
module seg7_display_ctrl #(
  parameter int PWM_PRESCALE = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [27:0] out_port,
  output logic        busy
`ifdef SEG7_DISPLAY_IRQ_EN
  ,
  output logic        irq
`endif
);
  localparam int PW = PWM_PRESCALE > 1 ? $clog2(PWM_PRESCALE) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
  state_t state, state_n;
  logic [15:0] value;
  logic [12:0] control;
  logic [3:0]  cnt;
  logic [35:0] sh;
  logic [27:0] display, blank_x, seg;
  logic        overflow, hex_pend, wr, wr_val, lit, wrap;
  logic [PW-1:0] pre;
  logic [3:0]  pwm_cnt;
  logic [31:0] status;
  logic        unused_bits;
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction
  // One double-dabble step on {bcd[19:0], bin[15:0]}: add 3 to nibbles >= 5, then shift left
  function automatic logic [35:0] dabble(input logic [35:0] s);
    logic [35:0] t;
    t = s;
    for (int i = 0; i < 5; i++)
      if (t[16+4*i +: 4] >= 4'd5) t[16+4*i +: 4] = t[16+4*i +: 4] + 4'd3;
    return {t[34:0], 1'b0};
  endfunction
  assign wr = chipselect & ~write_n;
  assign wr_val = wr & (address == 2'd0);
  assign busy = state != IDLE;
  assign unused_bits = ^writedata[31:16];
  assign wrap = pre == PW'(PWM_PRESCALE - 1);
  assign lit = (control[11:8] == 4'hF) | (pwm_cnt < control[11:8]);
  assign blank_x = {{7{control[7]}}, {7{control[6]}}, {7{control[5]}}, {7{control[4]}}};
  assign seg = (control[0] & lit) ? (display & ~blank_x) : '0;
`ifdef SEG7_DISPLAY_IRQ_EN
  assign status = {29'b0, irq, overflow, busy};
`else
  assign status = {30'b0, overflow, busy};
`endif
  // Combinational register read mux
  always_comb
    readdata = address == 2'd0 ? {16'b0, value} : address == 2'd1 ? {19'b0, control} : address == 2'd2 ? status : '0;
  // Next state: any VALUE write aborts and restarts (BCD) or idles (hex)
  always_comb begin
    state_n = state;
    state_n = wr_val ? (control[1] ? SHIFT : IDLE) : (state == SHIFT && cnt == 4'd15) ? LOAD : (state == LOAD) ? IDLE : state;
  end
  // Conversion state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  // Register file, conversion datapath and display register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      value <= '0;
      control <= '0;
      cnt <= '0;
      sh <= '0;
      display <= '0;
      overflow <= 1'b0;
      hex_pend <= 1'b0;
    end else begin
      if (wr && address == 2'd1) control <= writedata[12:0];
      if (wr_val) begin
        value <= writedata[15:0];
        cnt <= '0;
        sh <= {20'b0, writedata[15:0]};
        hex_pend <= ~control[1];
        if (!control[1]) overflow <= 1'b0;
      end else begin
        hex_pend <= 1'b0;
        if (state == SHIFT) begin
          sh <= dabble(sh);
          cnt <= cnt + 4'd1;
        end
      end
      if (hex_pend) display <= {glyph(value[15:12]), glyph(value[11:8]), glyph(value[7:4]), glyph(value[3:0])};
      if (state == LOAD && !wr_val) begin
        overflow <= value > 16'd9999;
        display <= value > 16'd9999 ? {4{7'h40}} : {glyph(sh[31:28]), glyph(sh[27:24]), glyph(sh[23:20]), glyph(sh[19:16])};
      end
    end
  // PWM prescaler and 16-step duty counter
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pre <= '0;
      pwm_cnt <= '0;
    end else begin
      pre <= wrap ? '0 : pre + 1'b1;
      if (wrap) pwm_cnt <= pwm_cnt + 4'd1;
    end
  // Registered segment output with polarity
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) out_port <= '0;
    else out_port <= control[12] ? ~seg : seg;
`ifdef SEG7_DISPLAY_IRQ_EN
  // Completion interrupt: set on an unaborted LOAD, cleared by a STATUS write; set wins
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) irq <= 1'b0;
    else if (state == LOAD && !wr_val) irq <= 1'b1;
    else if (wr && address == 2'd2) irq <= 1'b0;
`endif
endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb_seg7_display_ctrl: directed self-checking bench for seg7_display_ctrl
module tb_seg7_display_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [27:0] out_port;
  logic        busy;
`ifdef SEG7_DISPLAY_IRQ_EN
  logic        irq;
  localparam logic [31:0] IRQ_BIT = 32'h4;
`else
  localparam logic [31:0] IRQ_BIT = 32'h0;
`endif
  int pass = 0;
  int total = 0;
  localparam logic [27:0] DASH  = 28'h8102040;
  localparam logic [27:0] G1234 = 28'h0D6E7E6;
  localparam logic [27:0] G0000 = 28'h7EFDFBF;
  localparam logic [27:0] G0007 = 28'h7EFDF87;
  localparam logic [27:0] G0042 = 28'h7EFF35B;

  seg7_display_ctrl #(.PWM_PRESCALE(1)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port),
    .busy(busy)
`ifdef SEG7_DISPLAY_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    #12;
    total++; if (out_port !== 28'h0) $display("FAIL reset_out got=%h exp=0", out_port); else pass++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass++;
    for (int a = 0; a < 3; a++) begin
      rd(a[1:0], d);
      total++; if (d !== 32'h0) $display("FAIL reset_read%0d got=%h exp=0", a, d); else pass++;
    end
    @(negedge clk) reset_n = 1'b1;
    wr(2'd1, 32'h3);
    wr(2'd0, 32'h04D2);
    tick(3);
    total++; if (busy !== 1'b1) $display("FAIL midconv_busy got=%b exp=1", busy); else pass++;
    #2 reset_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL async_reset_busy got=%b exp=0", busy); else pass++;
    rd(2'd1, d);
    total++; if (d !== 32'h0) $display("FAIL async_reset_ctrl got=%h exp=0", d); else pass++;
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_hex;
    wr(2'd1, 32'h0F01);
    wr(2'd0, 32'h1234);
    tick(1);
    total++; if (out_port !== 28'h0) $display("FAIL hex_e1 got=%h exp=0", out_port); else pass++;
    tick(1);
    total++; if (out_port !== G1234) $display("FAIL hex_e2 got=%h exp=%h", out_port, G1234); else pass++;
    total++; if (busy !== 1'b0) $display("FAIL hex_busy got=%b exp=0", busy); else pass++;
  endtask

  task automatic test_bcd;
    logic [31:0] d;
    wr(2'd0, 32'h0);
    tick(2);
    total++; if (out_port !== G0000) $display("FAIL hex_zero got=%h exp=%h", out_port, G0000); else pass++;
    wr(2'd1, 32'h0F03);
    wr(2'd0, 32'h04D2);
    for (int i = 0; i <= 18; i++) begin
      if (i > 0) tick(1);
      total++; if (busy !== (i <= 16)) $display("FAIL bcd_busy c%0d got=%b exp=%b", i, busy, i <= 16); else pass++;
      total++; if (out_port !== (i >= 18 ? G1234 : G0000)) $display("FAIL bcd_out c%0d got=%h exp=%h", i, out_port, i >= 18 ? G1234 : G0000); else pass++;
    end
    rd(2'd2, d);
    total++; if ((d & 32'h3) !== 32'h0) $display("FAIL bcd_status got=%h exp=0", d); else pass++;
  endtask

  task automatic test_overflow_abort;
    logic [31:0] d;
    wr(2'd0, 32'd10000);
    tick(18);
    total++; if (out_port !== DASH) $display("FAIL ovf_out got=%h exp=%h", out_port, DASH); else pass++;
    rd(2'd2, d);
    total++; if ((d & 32'h3) !== 32'h2) $display("FAIL ovf_status got=%h exp=2", d); else pass++;
    wr(2'd0, 32'd7);
    tick(18);
    total++; if (out_port !== G0007) $display("FAIL bcd7_out got=%h exp=%h", out_port, G0007); else pass++;
    rd(2'd2, d);
    total++; if ((d & 32'h3) !== 32'h0) $display("FAIL bcd7_status got=%h exp=0", d); else pass++;
    wr(2'd2, 32'h0);
    wr(2'd0, 32'd10000);
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      total++; if (out_port === DASH) $display("FAIL abort_pre c%0d got=%h exp=not dash", i, out_port); else pass++;
    end
    wr(2'd0, 32'd42);
    for (int i = 1; i <= 18; i++) begin
      tick(1);
      total++; if (out_port === DASH) $display("FAIL abort_dash c%0d got=%h exp=not dash", i, out_port); else pass++;
      total++; if (busy !== (i <= 16)) $display("FAIL abort_busy c%0d got=%b exp=%b", i, busy, i <= 16); else pass++;
`ifdef SEG7_DISPLAY_IRQ_EN
      total++; if (irq !== (i >= 17)) $display("FAIL abort_irq c%0d got=%b exp=%b", i, irq, i >= 17); else pass++;
`endif
    end
    total++; if (out_port !== G0042) $display("FAIL abort_out got=%h exp=%h", out_port, G0042); else pass++;
    rd(2'd2, d);
    total++; if (d !== IRQ_BIT) $display("FAIL abort_status got=%h exp=%h", d, IRQ_BIT); else pass++;
  endtask

  task automatic test_blank_invert;
    logic [31:0] d;
    wr(2'd1, 32'h0F01);
    wr(2'd0, 32'h1234);
    tick(2);
    total++; if (out_port !== G1234) $display("FAIL bi_plain got=%h exp=%h", out_port, G1234); else pass++;
    wr(2'd1, 32'h0F11);
    total++; if (out_port !== G1234) $display("FAIL bi_blank_e0 got=%h exp=%h", out_port, G1234); else pass++;
    tick(1);
    total++; if (out_port !== 28'h0D6E780) $display("FAIL bi_blank got=%h exp=0d6e780", out_port); else pass++;
    wr(2'd1, 32'h1F11);
    tick(1);
    total++; if (out_port !== 28'hF29187F) $display("FAIL bi_blank_inv got=%h exp=f29187f", out_port); else pass++;
    wr(2'd1, 32'h1F01);
    tick(1);
    total++; if (out_port !== 28'hF291819) $display("FAIL bi_inv got=%h exp=f291819", out_port); else pass++;
    wr(2'd1, 32'h1F00);
    tick(1);
    total++; if (out_port !== 28'hFFFFFFF) $display("FAIL bi_dis_inv got=%h exp=fffffff", out_port); else pass++;
    wr(2'd1, 32'h0F00);
    tick(1);
    total++; if (out_port !== 28'h0) $display("FAIL bi_dis got=%h exp=0", out_port); else pass++;
    wr(2'd3, 32'hFFFF_FFFF);
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd0, d);
    total++; if (d !== 32'h1234) $display("FAIL rd_value got=%h exp=1234", d); else pass++;
    rd(2'd1, d);
    total++; if (d !== 32'h0F00) $display("FAIL rd_control got=%h exp=0f00", d); else pass++;
    rd(2'd3, d);
    total++; if (d !== 32'h0) $display("FAIL rd_reserved got=%h exp=0", d); else pass++;
  endtask

  task automatic test_pwm;
    logic [15:0] ctl [3] = '{16'h0801, 16'h0001, 16'h0F01};
    int exp_on [3] = '{16, 0, 32};
    int on;
    for (int k = 0; k < 3; k++) begin
      wr(2'd1, {16'b0, ctl[k]});
      tick(1);
      on = 0;
      for (int c = 0; c < 32; c++) begin
        if (out_port !== 28'h0) on++;
        tick(1);
      end
      total++; if (on !== exp_on[k]) $display("FAIL pwm_ctl%h on=%0d exp=%0d", ctl[k], on, exp_on[k]); else pass++;
    end
  endtask

`ifdef SEG7_DISPLAY_IRQ_EN
  task automatic test_irq;
    logic [31:0] d;
    wr(2'd1, 32'h0F03);
    wr(2'd2, 32'h0);
    total++; if (irq !== 1'b0) $display("FAIL irq_clr0 got=%b exp=0", irq); else pass++;
    wr(2'd0, 32'd5);
    tick(16);
    total++; if (irq !== 1'b0) $display("FAIL irq_early got=%b exp=0", irq); else pass++;
    tick(1);
    total++; if (irq !== 1'b1) $display("FAIL irq_set got=%b exp=1", irq); else pass++;
    rd(2'd2, d);
    total++; if (d !== 32'h4) $display("FAIL irq_status got=%h exp=4", d); else pass++;
    wr(2'd2, 32'h0);
    total++; if (irq !== 1'b0) $display("FAIL irq_clear got=%b exp=0", irq); else pass++;
    wr(2'd0, 32'd6);
    tick(16);
    wr(2'd2, 32'h0);
    total++; if (irq !== 1'b1) $display("FAIL irq_set_wins got=%b exp=1", irq); else pass++;
  endtask
`endif

  initial begin
    test_reset;
    test_hex;
    test_bcd;
    test_overflow_abort;
    test_blank_invert;
    test_pwm;
`ifdef SEG7_DISPLAY_IRQ_EN
    test_irq;
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/seg7_display_ctrl.md
Name: seg7_display_ctrl

Overview:
- Avalon-MM slave that owns the 28-bit segment bus feeding the four 7-segment digits on the pwm_ctrl board, replacing a raw PIO write of segment patterns.
- Software writes a 16-bit value. The block decodes it in hex or decimal (iterative binary-to-BCD), applies per-digit blanking and polarity, and PWM-dims the result.
- Sits in the Nios II system alongside the other slaves on the same clock/reset.

Parameters:
- PWM_PRESCALE, 256, clock cycles per PWM step; legal range >= 1. The 16-step PWM period = 16*PWM_PRESCALE cycles.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  register select: 0 VALUE, 1 CONTROL, 2 STATUS, 3 reserved
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data; combinational from address, zero wait states
- out_port  out  28  segments; digit i occupies [7i+6:7i]; bit 0 of each digit = segment a, bit 6 = segment g
- busy  out  1  BCD conversion in progress

Behaviour:
- Clocking/reset: one clock; reset is asynchronous, active-low. Reset clears all registers: value=0, control=0, busy=0, overflow=0, out_port=0.
- Write = chipselect & ~write_n.
- Reads:
  - Addr 0 returns {16'b0, value}.
  - Addr 1 returns {19'b0, control[12:0]}.
  - Addr 2 returns {30'b0, overflow, busy}.
  - Addr 3 returns 0.
- VALUE write (addr 0): latch writedata[15:0].
  - Hex mode (mode latched at write): the display register loads the 4 hex glyphs on the next edge.
  - BCD mode: start conversion; busy=1 from the next edge.
- Conversion FSM: IDLE -> SHIFT (16 cycles, double-dabble, one bit per cycle, add-3 on any BCD nibble >= 5 before the shift) -> LOAD (1 cycle) -> IDLE.
  - busy is high in SHIFT and LOAD.
  - The display register updates only in LOAD (atomic, no partial digits shown).
  - If value > 9999: overflow=1 and the display loads four dashes (segment g only, 7'h40 per digit). Otherwise overflow=0.
  - In hex mode, a VALUE write clears overflow.
- VALUE write while busy: abort, restart conversion from cycle 0 with the new value; the old result is never displayed.
- CONTROL write (addr 1) fields:
  - [0] enable
  - [1] bcd_mode
  - [7:4] blank mask (bit i blanks digit i)
  - [11:8] brightness
  - [12] invert (active-low segments)
  - Mode change during busy does not affect the running conversion.
  - Blank/brightness/invert/enable take effect at out_port one cycle after the write edge.
- Writes to addr 2/3 are ignored (except the IRQ clear under the optional feature).
- PWM:
  - Prescaler counts 0..PWM_PRESCALE-1; at wrap, the 4-bit pwm_cnt increments (wraps 15->0).
  - lit = (brightness == 15) | (pwm_cnt < brightness). Brightness 0 = dark.
- out_port (registered) = invert ? ~seg : seg, where seg = (enable & lit) ? (display & ~blank expansion) : 0.
  - With enable=0 and invert=1, out_port = 28'hFFFFFFF.
- Latency from VALUE write edge to out_port: hex 2 cycles; BCD 18 cycles.

Optional Feature:
- Macro: SEG7_DISPLAY_IRQ_EN.
- Defined:
  - Adds output irq (1 bit, reset 0).
  - irq is set on the LOAD cycle of any completed conversion; an aborted conversion does not set it.
  - Any write to addr 2 clears irq; if the clear coincides with a set, the set wins.
  - STATUS[2] reads irq.
- Undefined: no irq port; STATUS[2] reads 0.

Test Plan:
- Reset mid-conversion, then CONTROL=0x0F01, VALUE=0x1234 -> out_port=0x0D6E7E6 exactly 2 cycles after the write; busy stays 0.
- CONTROL=0x0F03, VALUE=0x04D2 -> busy high 17 cycles; out_port=0x0D6E7E6 at cycle 18; STATUS=0.
- BCD, VALUE=10000 -> out_port=0x8102040, STATUS[1]=1. A second VALUE write at cycle 5 of conversion (value 42) -> restart; final out_port shows 0042 glyphs 18 cycles after the second write; the dash pattern never appears.
- Hex 0x1234 with blank mask 0x1 -> 0x0D6E780; with invert also set -> 0xF29187F; with invert and no blank -> 0xF291819.
- PWM_PRESCALE=1, brightness 8 -> out_port nonzero for exactly 8 of every 16 cycles; brightness 0 -> always 0; brightness 15 -> always on.
- SEG7_DISPLAY_IRQ_EN: BCD completion -> irq=1; write addr 2 -> irq=0 next cycle; aborted conversion -> irq stays 0.
